audio_adc_rx: RTL

AUDIO_ADC_RX -- requirements
Module: audio_adc_rx

---
 rtl/audio_adc_rx.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/audio_adc_rx.sv
// Serial audio ADC receiver: captures I2S / left-justified stereo frames from an
// asynchronous codec bit clock and hands completed left/right pairs to a consumer.
module audio_adc_rx #(
    parameter int DATA_WIDTH = 16,
    parameter int I2S_DELAY  = 1
) (
    input  logic                  CLOCK_50,
    input  logic                  reset_n,
    input  logic                  AUD_BCLK,
    input  logic                  AUD_ADCLRCK,
    input  logic                  AUD_ADCDAT,
    input  logic                  adc_ready,
    input  logic                  overrun_clr,
    output logic [DATA_WIDTH-1:0] adc_left,
    output logic [DATA_WIDTH-1:0] adc_right,
    output logic                  adc_valid,
    output logic                  overrun,
    output logic                  aligned
);

    localparam int CNT_W = $clog2(DATA_WIDTH);

    typedef enum logic [1:0] {IDLE, SKIP, SHIFT, DRAIN} state_t;

    logic [1:0] bclk_sync_q, bclk_sync_d;
    logic [1:0] lrck_sync_q, lrck_sync_d;
    logic [1:0] dat_sync_q, dat_sync_d;
    logic       bclk_dly_q, bclk_dly_d;
    logic       lrck_dly_q, lrck_dly_d;

    always_comb begin
        bclk_sync_d = {bclk_sync_q[0], AUD_BCLK};
        lrck_sync_d = {lrck_sync_q[0], AUD_ADCLRCK};
        dat_sync_d  = {dat_sync_q[0], AUD_ADCDAT};
        bclk_dly_d  = bclk_sync_q[1];
        lrck_dly_d  = lrck_sync_q[1];
    end

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            bclk_sync_q <= '0;
            lrck_sync_q <= '0;
            dat_sync_q  <= '0;
            bclk_dly_q  <= 1'b0;
            lrck_dly_q  <= 1'b0;
        end else begin
            bclk_sync_q <= bclk_sync_d;
            lrck_sync_q <= lrck_sync_d;
            dat_sync_q  <= dat_sync_d;
            bclk_dly_q  <= bclk_dly_d;
            lrck_dly_q  <= lrck_dly_d;
        end
    end

    logic lrck_s, dat_s, bclk_rise, lrck_edge, lrck_fall;
    assign lrck_s    = lrck_sync_q[1];
    assign dat_s     = dat_sync_q[1];
    assign bclk_rise = bclk_sync_q[1] & ~bclk_dly_q;
    assign lrck_edge = lrck_s ^ lrck_dly_q;
    assign lrck_fall = lrck_dly_q & ~lrck_s;

    state_t                  state_q;
    logic [CNT_W-1:0]        cnt_q;
    logic                    chan_q;      // 0 = left, 1 = right
    logic                    left_got_q;  // left word of the current frame is held
    logic [DATA_WIDTH-1:0]   shift_q;
    logic [DATA_WIDTH-1:0]   hold_l_q;
    logic                    aligned_q;

    logic [DATA_WIDTH-1:0] shift_nxt;
    logic                  word_done, pair_done;
    state_t                start_state;

    assign shift_nxt   = {shift_q[DATA_WIDTH-2:0], dat_s};
    assign start_state = (I2S_DELAY != 0) ? SKIP : SHIFT;
    assign word_done   = (state_q == SHIFT) && bclk_rise && !lrck_edge &&
                         (cnt_q == CNT_W'(DATA_WIDTH - 1));
    // The right word is forwarded straight from the shifter so the pair is
    // visible on the cycle after its last bit strobe.
    assign pair_done   = word_done && chan_q && left_got_q;

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            chan_q     <= 1'b0;
            left_got_q <= 1'b0;
            shift_q    <= '0;
            hold_l_q   <= '0;
            aligned_q  <= 1'b0;
        end else if (state_q == IDLE) begin
            if (lrck_fall) begin
                state_q    <= start_state;
                chan_q     <= 1'b0;
                left_got_q <= 1'b0;
                cnt_q      <= '0;
                aligned_q  <= 1'b1;
            end
        end else if (lrck_edge) begin
            // Slot boundary: any partial word is abandoned; a new left slot
            // also forgets an unpaired left word.
            state_q <= start_state;
            chan_q  <= lrck_s;
            cnt_q   <= '0;
            if (!lrck_s) left_got_q <= 1'b0;
        end else if (bclk_rise) begin
            case (state_q)
                SKIP:  state_q <= SHIFT;
                SHIFT: begin
                    shift_q <= shift_nxt;
                    cnt_q   <= cnt_q + CNT_W'(1);
                    if (word_done) begin
                        state_q <= DRAIN;
                        if (!chan_q) begin
                            hold_l_q   <= shift_nxt;
                            left_got_q <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    logic [DATA_WIDTH-1:0] adc_left_q, adc_left_d, adc_right_q, adc_right_d;
    logic                  adc_valid_q, adc_valid_d, overrun_q, overrun_d;
    logic                  accept;

    assign accept = adc_valid_q & adc_ready;

    always_comb begin
        adc_left_d  = adc_left_q;
        adc_right_d = adc_right_q;
        adc_valid_d = adc_valid_q;
        overrun_d   = overrun_q;
        if (pair_done && (!adc_valid_q || accept)) begin
            adc_left_d  = hold_l_q;
            adc_right_d = shift_nxt;
            adc_valid_d = 1'b1;
        end else if (accept) begin
            adc_valid_d = 1'b0;
        end
        if (pair_done && adc_valid_q && !adc_ready) overrun_d = 1'b1;
        else if (overrun_clr)                       overrun_d = 1'b0;
    end

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            adc_left_q  <= '0;
            adc_right_q <= '0;
            adc_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            adc_left_q  <= adc_left_d;
            adc_right_q <= adc_right_d;
            adc_valid_q <= adc_valid_d;
            overrun_q   <= overrun_d;
        end
    end

    assign adc_left  = adc_left_q;
    assign adc_right = adc_right_q;
    assign adc_valid = adc_valid_q;
    assign overrun   = overrun_q;
    assign aligned   = aligned_q;

endmodule
